custom_ip_reg_bridge: RTL and testbench

- Register-side counterpart of the custom AXI IP register-to-hardware interface.
- Decodes a simple req/gnt register bus into per-channel write handshakes toward the IP (reg2ip).
- Captures IP-originated read data (ip2reg) into sticky read registers with valid and overrun status.
- Sits between the peripheral interconnect and the custom IP.

---
 rtl/custom_ip_reg_bridge_if.sv | 24 ++
 rtl/custom_ip_reg_bridge.sv | 151 +++++++++++++++
 tb/tb_custom_ip_reg_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/custom_ip_reg_bridge_if.sv
// Register-bus bundle (req/gnt with one-cycle response) between the interconnect
// and custom_ip_reg_bridge.
interface custom_ip_reg_bridge_if #(
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [7:0]        addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/custom_ip_reg_bridge.sv
// Register bus to per-channel IP write handshakes plus sticky IP read capture.
// Optional handshake timeout enabled by defining CUSTOM_IP_BRIDGE_TIMEOUT_EN.
module custom_ip_reg_bridge #(
  parameter int DATA_W      = 32,
  parameter int N_CH        = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  custom_ip_reg_bridge_if.slave    bus,
  output logic [N_CH*DATA_W-1:0]   reg2ip_data_o,
  output logic [N_CH-1:0]          reg2ip_en_o,
  input  logic [N_CH-1:0]          reg2ip_ack_i,
  input  logic [N_CH*DATA_W-1:0]   ip2reg_data_i,
  input  logic [N_CH-1:0]          ip2reg_en_i
);

  typedef enum logic [1:0] {IDLE, PEND, WAIT_LOW} wstate_e;

  localparam logic [3:0] NCH4 = 4'(N_CH);

  wstate_e           state_q [N_CH];
  logic [DATA_W-1:0] wdata_q [N_CH];
  logic [DATA_W-1:0] rd_q    [N_CH];
  logic [N_CH-1:0]   en_q, valid_q, ovr_q;
  logic              rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              tout_q;

`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]  cnt_q [N_CH];
`endif

  logic [5:0]        word;
  logic              aligned, idx_ok, hit_wd, hit_rd, hit_st;
  logic [N_CH-1:0]   sel, busy, wr_acc, rd_acc;
  logic              busy_hit, resp_err, w1c;
  logic [31:0]       status;
  logic [DATA_W-1:0] resp_rdata;

  always_comb begin
    word    = bus.addr_i[7:2];
    aligned = bus.addr_i[1:0] == 2'b00;
    idx_ok  = {1'b0, word[2:0]} < NCH4;
    hit_wd  = aligned && (word[5:3] == 3'd0) && idx_ok;
    hit_rd  = aligned && (word[5:3] == 3'd1) && idx_ok;
    hit_st  = aligned && (word == 6'd16);
    sel     = '0;
    busy    = '0;
    for (int n = 0; n < N_CH; n++) begin
      sel[n]  = word[2:0] == 3'(n);
      busy[n] = state_q[n] != IDLE;
    end
    busy_hit = hit_wd && bus.we_i && |(sel & busy);
    resp_err = !(hit_wd || hit_rd || hit_st) || busy_hit;
    status   = {tout_q, 7'd0, 8'(ovr_q), 8'(valid_q), 8'(busy)};
    resp_rdata = '0;
    wr_acc     = '0;
    rd_acc     = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (sel[n] && hit_wd) resp_rdata = wdata_q[n];
      if (sel[n] && hit_rd) resp_rdata = rd_q[n];
      wr_acc[n] = bus.req_i && bus.we_i && hit_wd && sel[n] && !busy[n];
      rd_acc[n] = bus.req_i && !bus.we_i && hit_rd && sel[n];
    end
    if (hit_st) resp_rdata = DATA_W'(status);
    w1c = bus.req_i && bus.we_i && hit_st;
  end

  // Bus response register, channel FSMs and read capture all advance on one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < N_CH; n++) begin
        state_q[n] <= IDLE;
        wdata_q[n] <= '0;
        rd_q[n]    <= '0;
`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
        cnt_q[n]   <= '0;
`endif
      end
      en_q     <= '0;
      valid_q  <= '0;
      ovr_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      tout_q   <= 1'b0;
    end else begin
      rvalid_q <= bus.req_i;
      err_q    <= bus.req_i && resp_err;
      rdata_q  <= (bus.req_i && !bus.we_i && !resp_err) ? resp_rdata : '0;
`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
      if (w1c && bus.wdata_i[31]) tout_q <= 1'b0;
`endif
      for (int n = 0; n < N_CH; n++) begin
        unique case (state_q[n])
          IDLE: if (wr_acc[n]) begin
            wdata_q[n] <= bus.wdata_i;
            state_q[n] <= PEND;
            en_q[n]    <= 1'b1;
          end
          PEND: if (reg2ip_ack_i[n]) begin
            state_q[n] <= WAIT_LOW;
            en_q[n]    <= 1'b0;
          end
          WAIT_LOW: if (!reg2ip_ack_i[n]) state_q[n] <= IDLE;
          default: begin
            state_q[n] <= IDLE;
            en_q[n]    <= 1'b0;
          end
        endcase
`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
        // Timeout overrides whatever the handshake decided this cycle.
        if (state_q[n] != IDLE) begin
          if (cnt_q[n] == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q[n] <= IDLE;
            en_q[n]    <= 1'b0;
            cnt_q[n]   <= '0;
            tout_q     <= 1'b1;
          end else begin
            cnt_q[n] <= cnt_q[n] + CNT_W'(1);
          end
        end else begin
          cnt_q[n] <= '0;
        end
`endif
        if (w1c && bus.wdata_i[16+n]) ovr_q[n] <= 1'b0;
        // A capture coinciding with a read of the same channel is not an overrun.
        if (ip2reg_en_i[n]) begin
          rd_q[n]    <= ip2reg_data_i[n*DATA_W +: DATA_W];
          valid_q[n] <= 1'b1;
          if (valid_q[n] && !rd_acc[n]) ovr_q[n] <= 1'b1;
        end else if (rd_acc[n]) begin
          valid_q[n] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < N_CH; n++) reg2ip_data_o[n*DATA_W +: DATA_W] = wdata_q[n];
  end

  assign reg2ip_en_o  = en_q;
  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Directed bench for custom_ip_reg_bridge: handshake, capture, overrun, errors, reset.
module tb_custom_ip_reg_bridge;
  localparam int DATA_W = 32;
  localparam int N_CH   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CH*DATA_W-1:0] r2i_data;
  logic [N_CH-1:0]        r2i_en;
  logic [N_CH-1:0]        ack = '0;
  logic [N_CH*DATA_W-1:0] ip_data = '0;
  logic [N_CH-1:0]        ip_en = '0;
  int tests_run  = 0;
  int tests_fail = 0;

  custom_ip_reg_bridge_if #(.DATA_W(DATA_W)) bif ();

  custom_ip_reg_bridge #(.DATA_W(DATA_W), .N_CH(N_CH), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bif.slave),
    .reg2ip_data_o(r2i_data), .reg2ip_en_o(r2i_en), .reg2ip_ack_i(ack),
    .ip2reg_data_i(ip_data), .ip2reg_en_i(ip_en)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic bus_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output logic rv);
    bif.req_i = 1'b1; bif.we_i = we; bif.addr_i = addr; bif.wdata_i = wd;
    @(negedge clk);
    rd = bif.rdata_o; er = bif.err_o; rv = bif.rvalid_o;
    bif.req_i = 1'b0; bif.we_i = 1'b0; bif.addr_i = '0; bif.wdata_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, rv;
    repeat (3) @(negedge clk);
    tests_run++; if (bif.rvalid_o !== 1'b0 || bif.err_o !== 1'b0 || bif.rdata_o !== 32'h0) begin tests_fail++; $display("FAIL reset_resp: got rv=%b err=%b rd=%h exp 0/0/0", bif.rvalid_o, bif.err_o, bif.rdata_o); end
    tests_run++; if (r2i_en !== 3'b000 || r2i_data !== 96'h0) begin tests_fail++; $display("FAIL reset_ip: got en=%b data=%h exp 0", r2i_en, r2i_data); end
    rst = 1'b0;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0 || er !== 1'b0 || rv !== 1'b1) begin tests_fail++; $display("FAIL reset_status: got rd=%h err=%b rv=%b exp 0/0/1", rd, er, rv); end
    @(negedge clk);
    tests_run++; if (bif.rvalid_o !== 1'b0) begin tests_fail++; $display("FAIL rvalid_pulse: got %b exp 0", bif.rvalid_o); end
  endtask

  task automatic test_write_handshake();
    logic [31:0] rd; logic er, rv; int en_cnt;
    bus_xfer(1'b1, 8'h00, 32'h2468, rd, er, rv);
    tests_run++; if (er !== 1'b0 || rv !== 1'b1) begin tests_fail++; $display("FAIL wr_resp: got err=%b rv=%b exp 0/1", er, rv); end
    en_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      if (r2i_en[0]) en_cnt++;
      tests_run++; if (r2i_en[0] !== (k <= 3)) begin tests_fail++; $display("FAIL hs_en k=%0d: got %b exp %b", k, r2i_en[0], (k <= 3)); end
      tests_run++; if (r2i_data[31:0] !== 32'h2468) begin tests_fail++; $display("FAIL hs_data k=%0d: got %h exp 00002468", k, r2i_data[31:0]); end
      ack[0] = (k == 3 || k == 4);
      bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
      tests_run++; if (rd[0] !== (k <= 5)) begin tests_fail++; $display("FAIL hs_busy k=%0d: got %b exp %b", k, rd[0], (k <= 5)); end
    end
    ack[0] = 1'b0;
    tests_run++; if (en_cnt !== 3) begin tests_fail++; $display("FAIL hs_en_len: got %0d exp 3", en_cnt); end
  endtask

  task automatic test_busy_write();
    logic [31:0] rd; logic er, rv;
    bus_xfer(1'b1, 8'h00, 32'h2468, rd, er, rv);
    bus_xfer(1'b1, 8'h00, 32'h9999, rd, er, rv);
    tests_run++; if (er !== 1'b1 || rv !== 1'b1) begin tests_fail++; $display("FAIL busy_err: got err=%b rv=%b exp 1/1", er, rv); end
    tests_run++; if (r2i_data[31:0] !== 32'h2468 || r2i_en[0] !== 1'b1) begin tests_fail++; $display("FAIL busy_keep: got data=%h en=%b exp 00002468/1", r2i_data[31:0], r2i_en[0]); end
    bus_xfer(1'b0, 8'h00, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h2468 || er !== 1'b0) begin tests_fail++; $display("FAIL wdata_rd: got rd=%h err=%b exp 00002468/0", rd, er); end
    ack[0] = 1'b1; @(negedge clk);
    ack[0] = 1'b0; @(negedge clk);
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0) begin tests_fail++; $display("FAIL busy_done: got %h exp 0", rd); end
  endtask

  task automatic test_ack_idle();
    logic [31:0] rd; logic er, rv;
    ack[2] = 1'b1;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0 || r2i_en !== 3'b000) begin tests_fail++; $display("FAIL ack_idle: got st=%h en=%b exp 0/0", rd, r2i_en); end
    ack[2] = 1'b0;
  endtask

  task automatic test_capture();
    logic [31:0] rd; logic er, rv;
    ip_data[63:32] = 32'h369C; ip_en = 3'b010; @(negedge clk); ip_en = '0;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h200) begin tests_fail++; $display("FAIL cap_valid: got %h exp 00000200", rd); end
    bus_xfer(1'b0, 8'h24, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h369C || er !== 1'b0) begin tests_fail++; $display("FAIL cap_read: got rd=%h err=%b exp 0000369c/0", rd, er); end
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0) begin tests_fail++; $display("FAIL cap_clr: got %h exp 0", rd); end
    bus_xfer(1'b0, 8'h24, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h369C) begin tests_fail++; $display("FAIL cap_reread: got %h exp 0000369c", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd; logic er, rv;
    ip_data[95:64] = 32'h48D0; ip_en = 3'b100; @(negedge clk);
    ip_data[95:64] = 32'h1111; @(negedge clk); ip_en = '0;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h40400) begin tests_fail++; $display("FAIL ovr_set: got %h exp 00040400", rd); end
    bus_xfer(1'b0, 8'h28, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h1111) begin tests_fail++; $display("FAIL ovr_data: got %h exp 00001111", rd); end
    bus_xfer(1'b1, 8'h40, 32'h40000, rd, er, rv);
    tests_run++; if (er !== 1'b0) begin tests_fail++; $display("FAIL w1c_err: got %b exp 0", er); end
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0) begin tests_fail++; $display("FAIL ovr_w1c: got %h exp 0", rd); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd; logic er, rv;
    ip_data[31:0] = 32'hAAAA; ip_en = 3'b001; @(negedge clk);
    ip_data[31:0] = 32'hBBBB;
    bus_xfer(1'b0, 8'h20, 32'h0, rd, er, rv); ip_en = '0;
    tests_run++; if (rd !== 32'hAAAA) begin tests_fail++; $display("FAIL sim_old: got %h exp 0000aaaa", rd); end
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h100) begin tests_fail++; $display("FAIL sim_status: got %h exp 00000100", rd); end
    // valid is still set: a capture now is an overrun racing a W1C of it
    ip_data[31:0] = 32'h3; ip_en = 3'b001;
    bus_xfer(1'b1, 8'h40, 32'h10000, rd, er, rv); ip_en = '0;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h10100) begin tests_fail++; $display("FAIL set_wins: got %h exp 00010100", rd); end
    bus_xfer(1'b0, 8'h20, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h3) begin tests_fail++; $display("FAIL sim_new: got %h exp 00000003", rd); end
    bus_xfer(1'b1, 8'h40, 32'h10000, rd, er, rv);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, rv;
    bus_xfer(1'b0, 8'h21, 32'h0, rd, er, rv);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || rv !== 1'b1) begin tests_fail++; $display("FAIL err_unal: got err=%b rd=%h rv=%b exp 1/0/1", er, rd, rv); end
    bus_xfer(1'b0, 8'h7C, 32'h0, rd, er, rv);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_fail++; $display("FAIL err_7c: got err=%b rd=%h exp 1/0", er, rd); end
    bus_xfer(1'b0, 8'h0C, 32'h0, rd, er, rv);
    tests_run++; if (er !== 1'b1) begin tests_fail++; $display("FAIL err_wd3: got %b exp 1", er); end
    bus_xfer(1'b1, 8'h01, 32'h5555, rd, er, rv);
    tests_run++; if (er !== 1'b1) begin tests_fail++; $display("FAIL err_wr_unal: got %b exp 1", er); end
    @(negedge clk);
    tests_run++; if (r2i_en !== 3'b000 || r2i_data[31:0] !== 32'h2468) begin tests_fail++; $display("FAIL err_noeffect: got en=%b d=%h exp 0/00002468", r2i_en, r2i_data[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, rv;
    bus_xfer(1'b1, 8'h00, 32'hA, rd, er, rv);
    tests_run++; if (er !== 1'b0) begin tests_fail++; $display("FAIL b2b_w0: got %b exp 0", er); end
    bus_xfer(1'b1, 8'h04, 32'hB, rd, er, rv);
    tests_run++; if (er !== 1'b0) begin tests_fail++; $display("FAIL b2b_w1: got %b exp 0", er); end
    bus_xfer(1'b1, 8'h08, 32'hC, rd, er, rv);
    tests_run++; if (er !== 1'b0) begin tests_fail++; $display("FAIL b2b_w2: got %b exp 0", er); end
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h7 || r2i_en !== 3'b111) begin tests_fail++; $display("FAIL b2b_busy: got st=%h en=%b exp 7/111", rd, r2i_en); end
    tests_run++; if (r2i_data !== {32'hC, 32'hB, 32'hA}) begin tests_fail++; $display("FAIL b2b_data: got %h", r2i_data); end
    ack = 3'b111; @(negedge clk);
    ack = 3'b000; @(negedge clk);
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0 || r2i_en !== 3'b000) begin tests_fail++; $display("FAIL b2b_done: got st=%h en=%b exp 0/0", rd, r2i_en); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rv;
    bus_xfer(1'b1, 8'h04, 32'h77, rd, er, rv);
    tests_run++; if (r2i_en[1] !== 1'b1) begin tests_fail++; $display("FAIL rm_pend: got %b exp 1", r2i_en[1]); end
    rst = 1'b1; @(negedge clk);
    tests_run++; if (r2i_en !== 3'b000 || r2i_data[63:32] !== 32'h0) begin tests_fail++; $display("FAIL rm_drop: got en=%b d=%h exp 0/0", r2i_en, r2i_data[63:32]); end
    rst = 1'b0;
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0) begin tests_fail++; $display("FAIL rm_status: got %h exp 0", rd); end
  endtask

`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic er, rv; int en_cnt;
    bus_xfer(1'b1, 8'h00, 32'h5A, rd, er, rv);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!r2i_en[0]) break;
      en_cnt++;
      @(negedge clk);
    end
    tests_run++; if (en_cnt !== 8) begin tests_fail++; $display("FAIL to_len: got %0d exp 8", en_cnt); end
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h8000_0000) begin tests_fail++; $display("FAIL to_status: got %h exp 80000000", rd); end
    bus_xfer(1'b1, 8'h00, 32'h5B, rd, er, rv);
    tests_run++; if (er !== 1'b0 || r2i_en[0] !== 1'b1) begin tests_fail++; $display("FAIL to_rewrite: got err=%b en=%b exp 0/1", er, r2i_en[0]); end
    repeat (10) @(negedge clk);
    bus_xfer(1'b1, 8'h40, 32'h8000_0000, rd, er, rv);
    bus_xfer(1'b0, 8'h40, 32'h0, rd, er, rv);
    tests_run++; if (rd !== 32'h0) begin tests_fail++; $display("FAIL to_clear: got %h exp 0", rd); end
  endtask
`endif

  initial begin
    bif.req_i = 1'b0; bif.we_i = 1'b0; bif.addr_i = '0; bif.wdata_i = '0;
    test_reset();
    test_write_handshake();
    test_busy_write();
    test_ack_idle();
    test_capture();
    test_overrun();
    test_simultaneous();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef CUSTOM_IP_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
